// File: rtl/masked_pattern_scanner_if.sv
// Config write port of masked_pattern_scanner: valid/ready handshake carrying
// a table select, an entry address and write data.
interface masked_pattern_scanner_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          valid;
  logic          ready;
  logic [1:0]    sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output valid, sel, addr, data, input ready);
  modport slave  (input valid, sel, addr, data, output ready);
endinterface

// File: rtl/masked_pattern_scanner.sv
// Captures the DATA beat at OFFSET after START and scans it against a mask/pattern
// table one entry per clock. Optional hit counter enabled by macro HIT_COUNT_EN.
module masked_pattern_scanner #(
  parameter int DW      = 32,
  parameter int ENTRIES = 16,
  parameter int TW      = 16,
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   data_valid,
  input  logic [DW-1:0]          data,
  masked_pattern_scanner_if.slave cfg,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [AW-1:0]          hit_idx,
  output logic [15:0]            hit_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, FINISH} state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tick;
  logic [TW-1:0]      offset;
  logic [DW-1:0]      cap;
  logic [AW-1:0]      idx;
  logic [DW-1:0]      mask_tab [ENTRIES];
  logic [DW-1:0]      pat_tab  [ENTRIES];
  logic [ENTRIES-1:0] en_tab;
  logic               capture;
  logic               entry_hit;
  logic               last_entry;
  logic               cfg_we;
  logic               addr_ok;

  assign capture    = (state == ARMED) && data_valid && (tick == offset);
  assign entry_hit  = en_tab[idx] && ((cap & mask_tab[idx]) == (pat_tab[idx] & mask_tab[idx]));
  assign last_entry = (idx == AW'(ENTRIES - 1));
  assign cfg_we     = cfg.valid && cfg.ready;
  assign addr_ok    = (int'(cfg.addr) < ENTRIES);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    cfg.ready  = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cfg.ready = 1'b1;
        if (start) state_next = ARMED;
      end
      ARMED:   if (capture) state_next = SCAN;
      SCAN:    if (entry_hit || last_entry) state_next = FINISH;
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Table is only writable in IDLE because ready is low elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mask_tab[i] <= '0;
        pat_tab[i]  <= '0;
      end
      mask_tab[0] <= DW'(32'h3);
      pat_tab[0]  <= DW'(32'h6);
      en_tab      <= ENTRIES'(1);
      offset      <= TW'(4);
    end else if (cfg_we) begin
      case (cfg.sel)
        2'd0:    if (addr_ok) mask_tab[cfg.addr] <= cfg.data;
        2'd1:    if (addr_ok) pat_tab[cfg.addr]  <= cfg.data;
        2'd2:    if (addr_ok) en_tab[cfg.addr]   <= cfg.data[0];
        default: offset <= cfg.data[TW-1:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick    <= '0;
      cap     <= '0;
      idx     <= '0;
      result  <= 1'b0;
      hit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tick    <= '0;
            result  <= 1'b0;
            hit_idx <= '0;
          end
        end
        ARMED: begin
          if (capture) begin
            cap <= data;
            idx <= '0;
          end else if (data_valid && (tick != '1)) begin
            tick <= tick + 1'b1;
          end
        end
        SCAN: begin
          if (entry_hit) begin
            result  <= 1'b1;
            hit_idx <= idx;
          end else if (last_entry) begin
            result <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      hit_cnt <= '0;
    else if ((state == FINISH) && result && (hit_cnt != 16'hFFFF))
      hit_cnt <= hit_cnt + 16'd1;
  end
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_masked_pattern_scanner.sv
// Bench for masked_pattern_scanner: directed scenarios plus randomized scans
// compared against a table model that finds the first matching entry with a plain loop.
module tb_masked_pattern_scanner;
  localparam int DW      = 32;
  localparam int ENTRIES = 12;
  localparam int TW      = 16;
  localparam int AW      = $clog2(ENTRIES);
  localparam int TIMEOUT = 200;

  typedef logic [DW-1:0] beat_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          busy, done, result;
  logic [AW-1:0] hit_idx;
  logic [15:0]   hit_cnt;

  int checks = 0;
  int errors = 0;
  bit stall_leak = 1'b0;

  logic [DW-1:0] m_mask [ENTRIES];
  logic [DW-1:0] m_pat  [ENTRIES];
  bit            m_en   [ENTRIES];
  int            m_offset;
  int            m_hits;

  masked_pattern_scanner_if #(.DW(DW), .AW(AW)) cfg_bus ();

  masked_pattern_scanner #(.DW(DW), .ENTRIES(ENTRIES), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .data(data),
    .cfg(cfg_bus), .busy(busy), .done(done), .result(result),
    .hit_idx(hit_idx), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_mask[i] = '0;
      m_pat[i]  = '0;
      m_en[i]   = 1'b0;
    end
    m_mask[0] = 32'h3;
    m_pat[0]  = 32'h6;
    m_en[0]   = 1'b1;
    m_offset  = 4;
    m_hits    = 0;
  endfunction

  function automatic void model_scan(input logic [DW-1:0] c, output bit hit, output int idx, output int lat);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < ENTRIES; i++)
      if (!hit && m_en[i] && ((c & m_mask[i]) == (m_pat[i] & m_mask[i]))) begin
        hit = 1'b1;
        idx = i;
      end
    lat = hit ? idx + 2 : ENTRIES + 1;
  endfunction

  function automatic int exp_hit_cnt();
`ifdef HIT_COUNT_EN
    return (m_hits > 65535) ? 65535 : m_hits;
`else
    return 0;
`endif
  endfunction

  function automatic beat_q_t make_beats(input logic [DW-1:0] cap);
    beat_q_t q;
    for (int i = 0; i < m_offset; i++) q.push_back(DW'($urandom));
    q.push_back(cap);
    return q;
  endfunction

  // Advance one cycle; note any cycle where the config port looks open while busy.
  task automatic step();
    if (busy === 1'b1 && cfg_bus.ready !== 1'b0) stall_leak = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [DW-1:0] d);
    int n;
    n = 0;
    cfg_bus.valid = 1'b1;
    cfg_bus.sel   = sel;
    cfg_bus.addr  = AW'(addr);
    cfg_bus.data  = d;
    while (cfg_bus.ready !== 1'b1 && n < TIMEOUT) begin step(); n++; end
    checks++;
    if (cfg_bus.ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cfg_accept got ready=%b want 1", cfg_bus.ready);
    end else begin
      case (sel)
        2'd0:    if (addr < ENTRIES) m_mask[addr] = d;
        2'd1:    if (addr < ENTRIES) m_pat[addr]  = d;
        2'd2:    if (addr < ENTRIES) m_en[addr]   = d[0];
        default: m_offset = int'(d[TW-1:0]);
      endcase
    end
    step();
    cfg_bus.valid = 1'b0;
  endtask

  // Pulse START then feed beats; returns in the first cycle after the capture edge.
  task automatic launch(input beat_q_t beats, input bit noise);
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (beats[i]) begin
      if (noise)
        repeat ($urandom_range(2)) begin
          data_valid = 1'b0;
          data       = DW'($urandom);
          start      = 1'($urandom_range(1));
          step();
        end
      start      = 1'b0;
      data_valid = 1'b1;
      data       = beats[i];
      step();
    end
    data_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit tmo);
    lat = 1;
    while (done !== 1'b1 && lat < TIMEOUT) begin step(); lat++; end
    tmo = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 1'b0) begin errors++; $display("[TB] FAIL reset_result got %b want 0", result); end
    checks++; if (hit_idx !== '0) begin errors++; $display("[TB] FAIL reset_hit_idx got %0d want 0", hit_idx); end
    checks++; if (hit_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_hit_cnt got %0d want 0", hit_cnt); end
    checks++; if (cfg_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", cfg_bus.ready); end
  endtask

  task automatic test_reset_defaults();
    beat_q_t b;
    int lat;
    bit tmo;
    b = '{32'h6, 32'h6, 32'h6, 32'h6, 32'h2};
    launch(b, 1'b0);
    wait_done(lat, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL defaults_timeout got none want done"); end
    checks++; if (result !== 1'b1) begin errors++; $display("[TB] FAIL defaults_result got %b want 1", result); end
    checks++; if (hit_idx !== '0) begin errors++; $display("[TB] FAIL defaults_hit_idx got %0d want 0", hit_idx); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL defaults_latency got %0d want 2", lat); end
    m_hits++;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL defaults_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL defaults_busy_after got %b want 0", busy); end
  endtask

  task automatic test_priority();
    int lat;
    bit tmo;
    cfg_write(2'd2, 0, 32'h0);
    cfg_write(2'd0, 3, 32'hFFFF_0000);
    cfg_write(2'd1, 3, 32'hA5A5_0000);
    cfg_write(2'd2, 3, 32'h1);
    cfg_write(2'd0, 7, 32'hFF00_0000);
    cfg_write(2'd1, 7, 32'hA500_0000);
    cfg_write(2'd2, 7, 32'h1);
    launch(make_beats(32'hA5A5_0000), 1'b1);
    wait_done(lat, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL priority_timeout got none want done"); end
    checks++; if (result !== 1'b1) begin errors++; $display("[TB] FAIL priority_result got %b want 1", result); end
    checks++; if (hit_idx !== AW'(3)) begin errors++; $display("[TB] FAIL priority_hit_idx got %0d want 3", hit_idx); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL priority_latency got %0d want 5", lat); end
    m_hits++;
    step();
  endtask

  task automatic test_no_hit();
    int lat;
    bit tmo;
    for (int i = 0; i < ENTRIES; i++) cfg_write(2'd2, i, 32'h0);
    for (int i = ENTRIES; i < (1 << AW); i++) cfg_write(2'd2, i, 32'h1);
    cfg_write(2'd3, 0, 32'hBEEF_0001);
    launch(make_beats(DW'($urandom)), 1'b1);
    wait_done(lat, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL nohit_timeout got none want done"); end
    checks++; if (result !== 1'b0) begin errors++; $display("[TB] FAIL nohit_result got %b want 0", result); end
    checks++; if (hit_idx !== '0) begin errors++; $display("[TB] FAIL nohit_hit_idx got %0d want 0", hit_idx); end
    checks++; if (lat != ENTRIES + 1) begin errors++; $display("[TB] FAIL nohit_latency got %0d want %0d", lat, ENTRIES + 1); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nohit_busy_drop got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL nohit_done_pulse got %b want 0", done); end
  endtask

  task automatic test_config_stall();
    beat_q_t b;
    int lat;
    bit tmo;
    cfg_write(2'd3, 0, 32'h2);
    cfg_bus.sel  = 2'd2;
    cfg_bus.addr = AW'(2);
    cfg_bus.data = 32'h1;
    stall_leak   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_bus.valid = 1'b1;
    b = make_beats(DW'($urandom));
    foreach (b[i]) begin
      data_valid = 1'b1;
      data       = b[i];
      step();
    end
    data_valid = 1'b0;
    wait_done(lat, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL stall_timeout got none want done"); end
    checks++; if (result !== 1'b0) begin errors++; $display("[TB] FAIL stall_frozen_result got %b want 0", result); end
    checks++; if (cfg_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_done got %b want 0", cfg_bus.ready); end
    step();
    checks++; if (stall_leak) begin errors++; $display("[TB] FAIL stall_ready_busy got ready=1 while busy want 0"); end
    checks++; if (cfg_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_idle got %b want 1", cfg_bus.ready); end
    step();
    cfg_bus.valid = 1'b0;
    m_en[2] = 1'b1;
    launch(make_beats(DW'($urandom)), 1'b0);
    wait_done(lat, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL stall_late_timeout got none want done"); end
    checks++; if (result !== 1'b1) begin errors++; $display("[TB] FAIL stall_late_result got %b want 1", result); end
    checks++; if (hit_idx !== AW'(2)) begin errors++; $display("[TB] FAIL stall_late_hit_idx got %0d want 2", hit_idx); end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL stall_late_latency got %0d want 4", lat); end
    m_hits++;
    step();
  endtask

  task automatic test_reset_mid_scan();
    beat_q_t b;
    int lat, e_idx, e_lat;
    bit tmo, e_hit;
    launch(make_beats(DW'($urandom)), 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    checks++; if (result !== 1'b0) begin errors++; $display("[TB] FAIL midrst_result got %b want 0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got %b want 0", done); end
    checks++; if (cfg_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", cfg_bus.ready); end
    checks++; if (hit_cnt !== 16'(exp_hit_cnt())) begin errors++; $display("[TB] FAIL midrst_hit_cnt got %0d want %0d", hit_cnt, exp_hit_cnt()); end
    cfg_write(2'd3, 0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      b = '{};
      b.push_back((k == 0) ? 32'h0 : 32'h2);
      model_scan(b[0], e_hit, e_idx, e_lat);
      launch(b, 1'b0);
      wait_done(lat, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL off0_timeout scan %0d got none want done", k); end
      checks++; if (result !== e_hit) begin errors++; $display("[TB] FAIL off0_result scan %0d got %b want %b", k, result, e_hit); end
      checks++; if (lat != e_lat) begin errors++; $display("[TB] FAIL off0_latency scan %0d got %0d want %0d", k, lat, e_lat); end
      if (e_hit) m_hits++;
      step();
    end
  endtask

  task automatic test_hit_count();
    beat_q_t b;
    int lat;
    bit tmo;
    logic [DW-1:0] caps [3];
    bit wants [3];
    caps  = '{32'h2, 32'h0, 32'h2};
    wants = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      b = make_beats(caps[k]);
      launch(b, 1'b0);
      wait_done(lat, tmo);
      checks++; if (result !== wants[k]) begin errors++; $display("[TB] FAIL hitcnt_result scan %0d got %b want %b", k, result, wants[k]); end
      if (wants[k]) m_hits++;
      step();
      checks++; if (hit_cnt !== 16'(exp_hit_cnt())) begin errors++; $display("[TB] FAIL hitcnt_value scan %0d got %0d want %0d", k, hit_cnt, exp_hit_cnt()); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] cap, wd;
    logic [1:0] sel;
    int nw, addr, lat, e_idx, e_lat;
    bit tmo, e_hit;
    for (int it = 0; it < 40; it++) begin
      cap = DW'($urandom);
      nw  = $urandom_range(4);
      for (int w = 0; w < nw; w++) begin
        sel  = 2'($urandom_range(3));
        addr = $urandom_range((1 << AW) - 1);
        case (sel)
          2'd0:    wd = DW'($urandom & $urandom & $urandom);
          2'd1:    wd = ($urandom_range(1) == 1) ? cap : DW'($urandom);
          2'd2:    wd = DW'($urandom);
          default: wd = {16'($urandom), 16'($urandom_range(4))};
        endcase
        cfg_write(sel, addr, wd);
      end
      model_scan(cap, e_hit, e_idx, e_lat);
      launch(make_beats(cap), 1'b1);
      wait_done(lat, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL rand_timeout it %0d got none want done", it); end
      checks++; if (result !== e_hit) begin errors++; $display("[TB] FAIL rand_result it %0d got %b want %b", it, result, e_hit); end
      checks++; if (hit_idx !== AW'(e_idx)) begin errors++; $display("[TB] FAIL rand_hit_idx it %0d got %0d want %0d", it, hit_idx, e_idx); end
      checks++; if (lat != e_lat) begin errors++; $display("[TB] FAIL rand_latency it %0d got %0d want %0d", it, lat, e_lat); end
      if (e_hit) m_hits++;
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle it %0d got done=%b busy=%b want 0 0", it, done, busy); end
      checks++; if (hit_cnt !== 16'(exp_hit_cnt())) begin errors++; $display("[TB] FAIL rand_hit_cnt it %0d got %0d want %0d", it, hit_cnt, exp_hit_cnt()); end
      repeat ($urandom_range(2)) step();
      checks++; if (result !== e_hit || hit_idx !== AW'(e_idx)) begin errors++; $display("[TB] FAIL rand_hold it %0d got %b/%0d want %b/%0d", it, result, hit_idx, e_hit, e_idx); end
    end
  endtask

  initial begin
    cfg_bus.valid = 1'b0;
    cfg_bus.sel   = 2'd0;
    cfg_bus.addr  = '0;
    cfg_bus.data  = '0;
    $display("[TB] masked_pattern_scanner bench start");
    test_reset();
    test_reset_defaults();
    test_priority();
    test_no_hit();
    test_config_stall();
    test_reset_mid_scan();
    test_hit_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
